// File: rtl/enc_pkt_sched.sv
// Round-robin scheduler feeding one 8b/10b packet encoder from NREQ byte streams.
// Optional stall timeout is compiled in with `define SCHED_TIMEOUT_EN.
module enc_pkt_sched #(
  parameter int NREQ    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              enc_pushin,
  output logic [8:0]        enc_datain,
  output logic              enc_startin,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              err_bc
);
  localparam logic [8:0] K28_1 = 9'h13C;
  localparam logic [8:0] EOPW  = 9'h0BC;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_EOP, S_TRAIL, S_GAP, S_DROP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [2:0]      ptr, ptr_nxt, grant_nxt, pick;
  logic            found;
  logic            push_nxt, start_nxt, err_nxt;
  logic [8:0]      data_nxt;
  logic [7:0]      vld8, lst8;
  logic [7:0][7:0] dat8;
  logic            gvalid, glast;
  logic [7:0]      gbyte;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt, to_nxt;
`endif

  // Widen request lines to 8 so a 3-bit index is always in range.
  always_comb begin
    vld8 = '0;
    lst8 = '0;
    dat8 = '0;
    for (int i = 0; i < NREQ; i++) begin
      vld8[i] = req_valid[i];
      lst8[i] = req_last[i];
      dat8[i] = req_data[8*i +: 8];
    end
  end

  assign gvalid = vld8[grant_id];
  assign glast  = lst8[grant_id];
  assign gbyte  = dat8[grant_id];

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      int t;
      t = int'(ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!found && vld8[3'(t)]) begin
        found = 1'b1;
        pick  = 3'(t);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    push_nxt  = 1'b0;
    data_nxt  = '0;
    start_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    to_nxt    = to_cnt;
`endif
    case (state)
      S_IDLE: if (found) begin
        grant_nxt = pick;
        state_nxt = S_PRE;
        cnt_nxt   = '0;
      end
      S_PRE: begin
        push_nxt  = 1'b1;
        data_nxt  = K28_1;
        start_nxt = (cnt == 4'd0);
        if (cnt == 4'd3) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
`ifdef SCHED_TIMEOUT_EN
          to_nxt    = '0;
`endif
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_DATA: begin
        if (gvalid) begin
          push_nxt = 1'b1;
          data_nxt = {1'b0, gbyte};
`ifdef SCHED_TIMEOUT_EN
          to_nxt   = '0;
`endif
          // A payload 0xBC already reads as the end marker downstream.
          if (gbyte == 8'hBC) begin
            err_nxt   = 1'b1;
            state_nxt = glast ? S_TRAIL : S_DROP;
            cnt_nxt   = '0;
          end else if (glast) begin
            state_nxt = S_EOP;
          end
        end
`ifdef SCHED_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT - 1)) begin
          push_nxt  = 1'b1;
          data_nxt  = EOPW;
          err_nxt   = 1'b1;
          state_nxt = S_DROP;
        end else begin
          to_nxt = to_cnt + TW'(1);
        end
`endif
      end
      S_EOP: begin
        push_nxt  = 1'b1;
        data_nxt  = EOPW;
        state_nxt = S_TRAIL;
        cnt_nxt   = '0;
      end
      S_TRAIL: begin
        if (cnt == 4'd4) begin
          ptr_nxt   = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
          state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt == 4'(GAP - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_DROP: if (gvalid && glast) begin
        state_nxt = S_TRAIL;
        cnt_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and busy are registered from the next state so they line up
  // with the state that actually consumes the byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      grant_id    <= '0;
      req_ready   <= '0;
      enc_pushin  <= 1'b0;
      enc_datain  <= '0;
      enc_startin <= 1'b0;
      busy        <= 1'b0;
      err_bc      <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ptr         <= ptr_nxt;
      grant_id    <= grant_nxt;
      req_ready   <= (state_nxt == S_DATA || state_nxt == S_DROP)
                     ? NREQ'(NREQ'(1) << grant_nxt) : '0;
      enc_pushin  <= push_nxt;
      enc_datain  <= data_nxt;
      enc_startin <= start_nxt;
      busy        <= !(state_nxt == S_IDLE || state_nxt == S_GAP);
      err_bc      <= err_nxt;
`ifdef SCHED_TIMEOUT_EN
      to_cnt      <= to_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_enc_pkt_sched.sv
// Scoreboard bench for enc_pkt_sched: source queues per requester drive the
// byte streams, expected encoder words are queued and checked on every push.
module tb_enc_pkt_sched;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              enc_pushin;
  logic [8:0]        enc_datain;
  logic              enc_startin;
  logic [2:0]        grant_id;
  logic              busy;
  logic              err_bc;

  enc_pkt_sched #(.NREQ(NREQ), .GAP(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .enc_pushin(enc_pushin), .enc_datain(enc_datain), .enc_startin(enc_startin),
    .grant_id(grant_id), .busy(busy), .err_bc(err_bc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [8:0] data;
    int         gap;    // idle busy cycles before this push, -1 = don't care
    logic       trail;  // this push is followed directly by the 5-cycle trailer
  } exp_t;

  exp_t       sb[$];
  logic [9:0] src_q[NREQ][$];  // {bubble, last, byte}
  logic [NREQ-1:0] pres;
  int n_cmp = 0, n_bad = 0, n_err = 0;
  int idle_run = 0, low_run = 0, last_low = 0, tr_cnt = 0;
  logic tr_on = 1'b0, prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic src_byte(input int r, input logic [7:0] b, input logic last);
    src_q[r].push_back({1'b0, last, b});
  endtask

  task automatic src_bub(input int r, input int n);
    for (int i = 0; i < n; i++) src_q[r].push_back(10'h200);
  endtask

  task automatic exp_pre();
    sb.push_back('{1'b1, 9'h13C, -1, 1'b0});
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 9'h13C, 0, 1'b0});
  endtask

  task automatic exp_w(input logic [8:0] d, input int gap, input logic trail);
    sb.push_back('{1'b0, d, gap, trail});
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {enc_pushin, enc_datain, enc_startin, req_ready, grant_id, busy, err_bc}, 0);
    reset = 1'b0;
  endtask

  // Source driver: handshake seen at the negedge retires at the next posedge.
  initial begin
    logic [NREQ-1:0] hs;
    req_valid = '0; req_data = '0; req_last = '0; pres = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (pres[i] && src_q[i].size() > 0 && (src_q[i][0][9] || hs[i]))
          void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          pres[i]            = 1'b1;
          req_valid[i]       = !src_q[i][0][9];
          req_last[i]        = src_q[i][0][8] && !src_q[i][0][9];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          pres[i]      = 1'b0;
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      idle_run = 0; tr_on = 1'b0; low_run = 0; prev_busy = 1'b0;
    end else begin
      if (busy) chk("rdy_mask", req_ready & ~(NREQ'(1) << grant_id), 0);
      if (err_bc) n_err++;
      if (tr_on) begin
        if (busy) tr_cnt++;
        else begin
          chk("trail_len", tr_cnt, 5);
          tr_on = 1'b0;
        end
      end
      if (enc_pushin) begin
        if (sb.size() == 0) chk("extra_push", sb.size(), 1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("enc_data", enc_datain, e.data);
          chk("enc_start", enc_startin, e.start);
          if (e.gap >= 0) chk("push_gap", idle_run, e.gap);
          if (e.trail) begin tr_on = 1'b1; tr_cnt = 1; end
        end
        idle_run = 0;
      end else if (busy) begin
        idle_run++;
      end
      if (busy && !prev_busy) begin last_low = low_run; low_run = 0; end
      if (!busy) low_run++;
      prev_busy = busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bit seen;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {enc_pushin, enc_datain, enc_startin, req_ready, grant_id, busy, err_bc}, 0);
    reset = 1'b0;

    // Basic 3-byte packet from requester 0.
    e0 = n_err;
    src_byte(0, 8'h11, 0); src_byte(0, 8'h22, 0); src_byte(0, 8'h33, 1);
    exp_pre();
    exp_w(9'h011, 0, 0); exp_w(9'h022, 0, 0); exp_w(9'h033, 0, 0); exp_w(9'h0BC, 0, 1);
    wait_drain(80);
    chk("t1_grant", grant_id, 0);
    chk("t1_err", n_err - e0, 0);

    // Simultaneous requesters 1 and 2 from pointer 0.
    do_reset();
    src_byte(1, 8'h41, 0); src_byte(1, 8'h42, 1);
    src_byte(2, 8'h51, 1);
    exp_pre(); exp_w(9'h041, 0, 0); exp_w(9'h042, 0, 0); exp_w(9'h0BC, 0, 1);
    exp_pre(); exp_w(9'h051, 0, 0); exp_w(9'h0BC, 0, 1);
    wait_drain(120);
    chk("t2_gap_low", last_low, 3);
    chk("t2_grant", grant_id, 2);

    // Three bubbles mid-packet on requester 3.
    src_byte(3, 8'h61, 0); src_bub(3, 3); src_byte(3, 8'h62, 0); src_byte(3, 8'h63, 1);
    exp_pre(); exp_w(9'h061, 0, 0); exp_w(9'h062, 3, 0); exp_w(9'h063, 0, 0);
    exp_w(9'h0BC, 0, 1);
    wait_drain(80);
    chk("t3_grant", grant_id, 3);

    // Payload 0xBC collides with the end marker.
    e0 = n_err;
    src_byte(0, 8'hAA, 0); src_byte(0, 8'hBC, 0); src_byte(0, 8'hCC, 1);
    exp_pre(); exp_w(9'h0AA, 0, 0); exp_w(9'h0BC, 0, 0);
    wait_drain(80);
    chk("t4_err", n_err - e0, 1);
    chk("t4_drained", src_q[0].size(), 0);

    // BC as the last byte goes straight to the trailer.
    e0 = n_err;
    src_byte(1, 8'hBC, 1);
    exp_pre(); exp_w(9'h0BC, 0, 1);
    wait_drain(80);
    chk("t4b_err", n_err - e0, 1);

    // Reset during DATA aborts the packet.
    src_byte(3, 8'h71, 0); src_byte(3, 8'h72, 0); src_byte(3, 8'h73, 0);
    src_byte(3, 8'h74, 0); src_byte(3, 8'h75, 1);
    exp_pre(); exp_w(9'h071, 0, 0); exp_w(9'h072, 0, 0); exp_w(9'h073, 0, 0);
    exp_w(9'h074, 0, 0); exp_w(9'h075, 0, 0); exp_w(9'h0BC, 0, 1);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[3]) seen = 1'b1;
    end
    chk("t5_ready_seen", seen, 1);
    do_reset();
    src_byte(1, 8'h81, 1);
    exp_pre(); exp_w(9'h081, 0, 0); exp_w(9'h0BC, 0, 1);
    wait_drain(80);
    chk("t5_grant", grant_id, 1);

`ifdef SCHED_TIMEOUT_EN
    // Stall for longer than TIMEOUT after the first byte.
    e0 = n_err;
    src_byte(1, 8'h91, 0); src_bub(1, 18); src_byte(1, 8'h92, 1);
    exp_pre(); exp_w(9'h091, 0, 0); exp_w(9'h0BC, 15, 0);
    wait_drain(120);
    chk("t6_err", n_err - e0, 1);
    chk("t6_drained", src_q[1].size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
